// File: rtl/chnl_rx_sched.sv
// chnl_rx_sched: round-robin scheduler merging N val/rdy streams into one consumer with bounded bursts.
// Define CHNL_RX_SCHED_OUTREG_EN to register the outputs through a 2-entry skid buffer.
module chnl_rx_sched #(
   parameter int N = 2,
   parameter int W = 32,
   parameter int MAX_BURST = 16,
   parameter int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   i_val,
   output logic [N-1:0]   i_rdy,
   input  logic [N*W-1:0] i_data,
   output logic           o_val,
   input  logic           o_rdy,
   output logic [W-1:0]   o_data,
   output logic [SW-1:0]  o_src,
   output logic           busy
);
   localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CLAST = CW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   state_t state, state_n;
   logic [SW-1:0] g, g_n, last, last_n, pick;
   logic [CW-1:0] cnt, cnt_n;
   logic [W-1:0] din [N];
   logic [2*N-1:0] rot;
   logic found, ready, beat;
   for (genvar k = 0; k < N; k++) begin : g_din
      assign din[k] = i_data[k*W +: W];
   end
   // rotate the request vector so bit 0 is the requester just after last
   always_comb begin
      rot = {i_val, i_val} >> (int'(last) + 1);
      found = 1'b0;
      pick = last;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            pick = SW'((int'(last) + 1 + i) % N);
         end
      end
   end
   always_comb begin
      state_n = state;
      g_n = g;
      cnt_n = cnt;
      last_n = last;
      i_rdy = '0;
      beat = (state == S_GRANT) && i_val[g] && ready;
      if (state == S_IDLE) begin
         if (found) begin
            state_n = S_GRANT;
            g_n = pick;
            cnt_n = '0;
         end
      end else begin
         i_rdy[g] = ready;
         if (!i_val[g] || (beat && MAX_BURST != 0 && cnt == CLAST)) begin
            state_n = S_IDLE;
            last_n = g;
         end else if (beat) begin
            cnt_n = (&cnt) ? cnt : cnt + CW'(1);
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         g <= '0;
         cnt <= '0;
         last <= SW'(N - 1);
      end else begin
         state <= state_n;
         g <= g_n;
         cnt <= cnt_n;
         last <= last_n;
      end
   end
   assign busy = (state == S_GRANT);
`ifdef CHNL_RX_SCHED_OUTREG_EN
   logic [SW+W-1:0] buf_q [2];
   logic wp, rp, pop;
   logic [1:0] fill;
   assign ready = (fill != 2'd2);
   assign o_val = (fill != 2'd0);
   assign pop = o_val && o_rdy;
   assign {o_src, o_data} = buf_q[rp];
   always_ff @(posedge clk) begin
      if (beat) buf_q[wp] <= {g, din[g]};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= 1'b0;
         rp <= 1'b0;
         fill <= '0;
      end else begin
         wp <= wp ^ beat;
         rp <= rp ^ pop;
         fill <= fill + {1'b0, beat} - {1'b0, pop};
      end
   end
`else
   assign ready = o_rdy;
   assign o_val = busy && i_val[g];
   assign o_data = din[g];
   assign o_src = g;
`endif
endmodule
